// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array host side: geometry, bus widths,
// beat counts, the result timeout and the stream-driver FSM state encoding.
package systolic_pkg;
  localparam int N              = 4;
  localparam int ELEM_W         = 8;
  localparam int ACC_W          = 32;
  localparam int BUS_W          = 64;
  localparam int TX_BEATS       = 4;
  localparam int RX_BEATS       = 8;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam int IDLE_CNT_W     = 16;

  localparam int MAT_W = N * N * ELEM_W;  // flattened operand matrix
  localparam int RES_W = N * N * ACC_W;   // flattened result matrix

  // mat_t[N-1-r][N-1-c] is element [r][c], so row 0 / column 0 sit in the MSBs.
  typedef logic [N-1:0][N-1:0][ELEM_W-1:0] mat_t;
  // res_t[RX_BEATS-1-j] holds result beat j (elements 2j, 2j+1).
  typedef logic [RX_BEATS-1:0][BUS_W-1:0]  res_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    WAIT_RES = 3'd2,
    RECV     = 3'd3,
    FIN      = 3'd4
  } state_e;
endpackage

// File: rtl/matrix_stream_driver.sv
// Host-side driver for a 4x4 systolic multiply.
// Latches A and B on start, streams four operand beats (A row k | B column k)
// over a valid/ready channel, collects eight result beats (two C elements per
// beat, row-major), then pulses done. A watchdog aborts the result phase if no
// beat arrives for TIMEOUT_CYCLES cycles and raises a sticky timeout_err.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start                 one-cycle run request (honoured only in IDLE)
//   a_flat, b_flat        signed 8-bit matrices, row-major, [0][0] in MSBs
//   tx_data/valid/ready   operand stream to the array
//   rx_data/valid/ready   result stream from the array
//   result                signed 32-bit C = A x B, row-major, [0][0] in MSBs
//   busy, done            not-IDLE flag, one-cycle completion pulse
//   timeout_err           sticky result-timeout flag, cleared by next start
module matrix_stream_driver
  import systolic_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [MAT_W-1:0] a_flat,
  input  logic [MAT_W-1:0] b_flat,
  output logic [BUS_W-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [BUS_W-1:0] rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [RES_W-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);
  localparam int KW = $clog2(TX_BEATS);
  localparam int JW = $clog2(RX_BEATS);
  localparam logic [KW-1:0]         TX_LAST = KW'(TX_BEATS - 1);
  localparam logic [JW-1:0]         RX_LAST = JW'(RX_BEATS - 1);
  localparam logic [IDLE_CNT_W-1:0] TO_LIM  = IDLE_CNT_W'(TIMEOUT_CYCLES);

  state_e                  state_q, state_d;
  mat_t                    a_q, a_d, b_q, b_d;
  logic [KW-1:0]           tx_k_q, tx_k_d;
  logic [JW-1:0]           rx_j_q, rx_j_d;
  logic [IDLE_CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  res_t                    result_q, result_d;
  logic                    timeout_err_q, timeout_err_d;

  logic                    tx_fire, rx_fire, timeout_hit;
  logic [IDLE_CNT_W-1:0]   idle_cnt_inc;
  logic [KW-1:0]           k_idx;
  logic [N-1:0][ELEM_W-1:0] a_row, b_col;

  // rx_ready is only high in WAIT_RES/RECV, so rx_fire alone keeps stray
  // rx_valid in other states from touching result or counters.
  assign tx_fire      = tx_valid & tx_ready;
  assign rx_fire      = rx_valid & rx_ready;
  assign idle_cnt_inc = idle_cnt_q + 1'b1;
  assign timeout_hit  = rx_ready & ~rx_fire & (idle_cnt_inc == TO_LIM);

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      tx_k_q        <= '0;
      rx_j_q        <= '0;
      idle_cnt_q    <= '0;
      result_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      tx_k_q        <= tx_k_d;
      rx_j_q        <= rx_j_d;
      idle_cnt_q    <= idle_cnt_d;
      result_q      <= result_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start) state_d = SEND;
      SEND:     if (tx_fire && tx_k_q == TX_LAST) state_d = WAIT_RES;
      WAIT_RES: if (rx_fire) state_d = (rx_j_q == RX_LAST) ? FIN : RECV;
                else if (timeout_hit) state_d = IDLE;
      RECV:     if (rx_fire && rx_j_q == RX_LAST) state_d = FIN;
                else if (timeout_hit) state_d = IDLE;
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Datapath next values: operand latch, beat counters, result capture, watchdog.
  always_comb begin
    a_d           = a_q;
    b_d           = b_q;
    tx_k_d        = tx_k_q;
    rx_j_d        = rx_j_q;
    idle_cnt_d    = idle_cnt_q;
    result_d      = result_q;
    timeout_err_d = timeout_err_q;
    if (state_q == IDLE && start) begin
      a_d           = a_flat;
      b_d           = b_flat;
      tx_k_d        = '0;
      rx_j_d        = '0;
      idle_cnt_d    = '0;
      timeout_err_d = 1'b0;
    end
    if (tx_fire) tx_k_d = tx_k_q + 1'b1;
    if (rx_fire) begin
      result_d[RX_LAST - rx_j_q] = rx_data;
      rx_j_d     = rx_j_q + 1'b1;
      idle_cnt_d = '0;
    end else if (timeout_hit) begin
      idle_cnt_d    = '0;
      timeout_err_d = 1'b1;
    end else if (rx_ready) begin
      idle_cnt_d = idle_cnt_inc;
    end
  end

  // Output logic, including the operand slicer: beat k = A row k | B column k.
  always_comb begin
    k_idx = TX_LAST - tx_k_q;
    a_row = a_q[k_idx];
    for (int r = 0; r < N; r++) b_col[r] = b_q[r][k_idx];
    tx_valid = (state_q == SEND);
    tx_data  = tx_valid ? {a_row, b_col} : '0;
    rx_ready = (state_q == WAIT_RES) || (state_q == RECV);
    busy     = (state_q != IDLE);
    done     = (state_q == FIN);
  end

  assign result      = result_q;
  assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_matrix_stream_driver.sv
// Directed bench for matrix_stream_driver with a small array model that
// multiplies the captured operand beats and returns the product as result beats.
module tb_matrix_stream_driver;
  logic         clk = 1'b0;
  logic         reset, start, tx_valid, tx_ready, rx_valid, rx_ready;
  logic         busy, done, timeout_err;
  logic [127:0] a_flat, b_flat;
  logic [63:0]  tx_data, rx_data;
  logic [511:0] result;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [127:0] MAT_I   = 128'h01000000_00010000_00000100_00000001;
  localparam logic [127:0] MAT_SEQ = 128'h01020304_05060708_090A0B0C_0D0E0F10;
  localparam logic [127:0] MAT_NEG = {16{8'h80}};
  localparam logic [127:0] MAT_TWO = {16{8'h02}};
  localparam logic [511:0] EXP_NEG = {16{32'h00010000}};
  localparam logic [511:0] EXP_TWO = {16{32'h00000002}};

  always #5 clk = ~clk;

  matrix_stream_driver dut (
    .clk(clk), .reset(reset), .start(start), .a_flat(a_flat), .b_flat(b_flat),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .result(result), .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: capture accepted operand beats, check held beats, count done pulses.
  logic [63:0] cap [0:127];
  int          ncap = 0;
  int          done_cnt = 0;
  logic        hold_pend = 1'b0;
  logic [63:0] hold_data;

  always @(negedge clk) begin
    if (hold_pend && !reset) begin
      chk("tx_hold_valid", 512'(tx_valid), 512'(1));
      chk("tx_hold_data", 512'(tx_data), 512'(hold_data));
    end
    hold_pend = !reset && tx_valid && !tx_ready;
    hold_data = tx_data;
    if (!reset && tx_valid && tx_ready && ncap < 128) begin
      cap[ncap] = tx_data;
      ncap++;
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [127:0] a, input logic [127:0] b);
    a_flat = a; b_flat = b; start = 1'b1;
    tick();
    start = 1'b0; a_flat = '0; b_flat = '0;
  endtask

  // Run the operand phase until the driver is waiting for results.
  task automatic wait_tx(input int budget, input bit toggle);
    int n = 0;
    while (!rx_ready && n < budget) begin
      if (toggle) tx_ready = ~tx_ready;
      tick();
      n++;
    end
    tx_ready = 1'b1;
    chk("tx_phase_end", 512'(rx_ready), 512'(1));
    chk("tx_valid_in_wait", 512'(tx_valid), 512'(0));
  endtask

  // Array model: C[i][j] = sum_m A[i][m]*B[m][j], A row i from beat i, B column j from beat j.
  function automatic logic [511:0] model_c(input int base);
    logic [511:0]      c = '0;
    logic signed [7:0] x, y;
    int                s;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int m = 0; m < 4; m++) begin
          x = cap[base+i][63-8*m -: 8];
          y = cap[base+j][31-8*m -: 8];
          s += int'(x) * int'(y);
        end
        c[511-32*(4*i+j) -: 32] = 32'(s);
      end
    return c;
  endfunction

  task automatic finish_op(input string tag, input int base, input logic [511:0] exp);
    logic [511:0] c;
    int           d0;
    c = model_c(base);
    for (int j = 0; j < 8; j++) begin
      rx_valid = 1'b1;
      rx_data  = c[511-64*j -: 64];
      tick();
    end
    rx_valid = 1'b0; rx_data = '0;
    chk({tag, "_done"}, 512'(done), 512'(1));
    chk({tag, "_result"}, result, exp);
    d0 = done_cnt;
    tick();
    chk({tag, "_done_drop"}, 512'(done), 512'(0));
    chk({tag, "_idle"}, 512'(busy), 512'(0));
    chk({tag, "_done_once"}, 512'(done_cnt), 512'(d0 + 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] exp_seq;
    int           base, d0, n;
    for (int e = 0; e < 16; e++) exp_seq[511-32*e -: 32] = 32'(e + 1);

    reset = 1'b1; start = 1'b0; a_flat = '0; b_flat = '0;
    tx_ready = 1'b1; rx_valid = 1'b0; rx_data = '0;
    repeat (3) tick();
    chk("rst_tx_valid", 512'(tx_valid), 512'(0));
    chk("rst_tx_data", 512'(tx_data), 512'(0));
    chk("rst_rx_ready", 512'(rx_ready), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_done", 512'(done), 512'(0));
    chk("rst_timeout", 512'(timeout_err), 512'(0));
    chk("rst_result", result, 512'(0));
    reset = 1'b0;

    // Identity x 1..16, tx_ready held high.
    base = ncap;
    a_flat = MAT_I; b_flat = MAT_SEQ; start = 1'b1;
    chk("idle_before_start", 512'(tx_valid), 512'(0));
    tick();
    start = 1'b0; a_flat = '0; b_flat = '0;
    chk("first_valid", 512'(tx_valid), 512'(1));
    chk("busy_send", 512'(busy), 512'(1));
    // A row 0 = 1,0,0,0 ; B column 0 = 1,5,9,13
    chk("ident_beat0", 512'(tx_data), 512'(64'h01000000_0105090D));
    wait_tx(20, 1'b0);
    chk("ident_tx_count", 512'(ncap - base), 512'(4));
    chk("ident_beat3", 512'(cap[base+3]), 512'(64'h00000001_04080C10));
    finish_op("ident", base, exp_seq);

    // 1..16 x identity with tx_ready toggling every cycle.
    base = ncap;
    go(MAT_SEQ, MAT_I);
    wait_tx(40, 1'b1);
    chk("tog_tx_count", 512'(ncap - base), 512'(4));
    chk("tog_beat0", 512'(cap[base+0]), 512'(64'h01020304_01000000));
    chk("tog_beat1", 512'(cap[base+1]), 512'(64'h05060708_00010000));
    chk("tog_beat2", 512'(cap[base+2]), 512'(64'h090A0B0C_00000100));
    chk("tog_beat3", 512'(cap[base+3]), 512'(64'h0D0E0F10_00000001));
    finish_op("tog", base, exp_seq);

    // All -128: each element is 4 * 16384 = 65536.
    base = ncap;
    go(MAT_NEG, MAT_NEG);
    chk("neg_beat0", 512'(tx_data), 512'(64'h80808080_80808080));
    wait_tx(20, 1'b0);
    finish_op("neg", base, EXP_NEG);

    // Result timeout: no rx beats after the operand phase.
    go(MAT_I, MAT_SEQ);
    wait_tx(20, 1'b0);
    d0 = done_cnt;
    n = 0;
    while (busy && n < 1100) begin
      tick();
      n++;
    end
    chk("to_cycles", 512'(n), 512'(1000));
    chk("to_flag", 512'(timeout_err), 512'(1));
    chk("to_idle", 512'(busy), 512'(0));
    chk("to_no_done", 512'(done_cnt), 512'(d0));
    chk("to_result_kept", result, EXP_NEG);
    base = ncap;
    go(MAT_SEQ, MAT_I);
    chk("to_cleared", 512'(timeout_err), 512'(0));
    wait_tx(20, 1'b0);
    finish_op("after_to", base, exp_seq);

    // Reset while beat 2 is on offer.
    base = ncap;
    tx_ready = 1'b0;
    go(MAT_SEQ, MAT_I);
    tx_ready = 1'b1;
    tick();
    tick();
    tx_ready = 1'b0;
    chk("rst_mid_count", 512'(ncap - base), 512'(2));
    chk("rst_mid_beat2", 512'(tx_data), 512'(64'h090A0B0C_00000100));
    reset = 1'b1; tx_ready = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_valid", 512'(tx_valid), 512'(0));
    chk("rst_mid_busy", 512'(busy), 512'(0));
    chk("rst_mid_result", result, 512'(0));
    base = ncap;
    go(MAT_SEQ, MAT_I);
    chk("restart_beat0", 512'(tx_data), 512'(64'h01020304_01000000));
    wait_tx(20, 1'b0);
    chk("restart_count", 512'(ncap - base), 512'(4));
    finish_op("restart", base, exp_seq);

    // rx_valid in IDLE, then start and rx_valid while busy: all ignored.
    rx_valid = 1'b1; rx_data = 64'hDEADBEEF_CAFEF00D;
    repeat (3) tick();
    rx_valid = 1'b0; rx_data = '0;
    chk("idle_rx_result", result, exp_seq);
    chk("idle_rx_busy", 512'(busy), 512'(0));
    base = ncap;
    tx_ready = 1'b0;
    go(MAT_I, MAT_TWO);
    a_flat = MAT_SEQ; b_flat = MAT_SEQ; start = 1'b1;
    rx_valid = 1'b1; rx_data = 64'h11111111_22222222;
    tick();
    start = 1'b0;
    tick();
    rx_valid = 1'b0; rx_data = '0; a_flat = '0; b_flat = '0;
    chk("busy_start_busy", 512'(busy), 512'(1));
    chk("busy_start_beat0", 512'(tx_data), 512'(64'h01000000_02020202));
    chk("busy_rx_result", result, exp_seq);
    tx_ready = 1'b1;
    wait_tx(20, 1'b0);
    chk("busy_start_count", 512'(ncap - base), 512'(4));
    finish_op("busy_start", base, EXP_TWO);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
